hazard_scoreboard: RTL

//  ID-stage scoreboard: producer-side complement of the EX/MEM forwarding unit. Tracks destination regs whose

---
 rtl/hazard_scoreboard.sv | 133 +++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register countdowns for results that cannot be
// forwarded in time, plus the issue/complete FSM of the single multi-cycle unit.
module hazard_scoreboard #(
    parameter int LOAD_LAT = 1,
    parameter int LONG_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_valid,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_useRs,
    input  logic        ID_useRt,
    input  logic        ID_regWrite,
    input  logic [4:0]  ID_rd,
    input  logic        ID_isLoad,
    input  logic        ID_isLong,
    input  logic        flush,
    output logic        stall,
    output logic        bubble,
    output logic        long_done,
    output logic [4:0]  long_rd,
    output logic [31:0] pending
);

    localparam int MAXL = (LOAD_LAT > LONG_LAT) ? LOAD_LAT : LONG_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic [4:0]    long_rd_q, long_rd_d;
    logic [CW-1:0] cnt_q [32];
    logic [CW-1:0] cnt_d [32];
    logic          issue_s;
    logic          long_issue_s;
    logic          set_s;
    logic [CW-1:0] set_val_s;

    // Hazard detection: RAW on either source, WAW on destination, structural on the long unit
    always_comb begin
        stall = ID_valid & ~flush & (
                    (ID_useRs    & (cnt_q[ID_rs] != {CW{1'b0}})) |
                    (ID_useRt    & (cnt_q[ID_rt] != {CW{1'b0}})) |
                    (ID_regWrite & (cnt_q[ID_rd] != {CW{1'b0}})) |
                    (ID_isLong   & (state_q == BUSY)));
        bubble       = stall;
        issue_s      = ID_valid & ~flush & ~stall;
        long_issue_s = issue_s & ID_isLong;
        set_s        = issue_s & ID_regWrite & (ID_rd != 5'd0) & (ID_isLong | ID_isLoad);
        set_val_s    = ID_isLong ? CW'(LONG_LAT) : CW'(LOAD_LAT);
    end

    // Countdown update: a fresh producer overrides the decrement of the same register
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            if (set_s && (ID_rd == 5'(r))) begin
                cnt_d[r] = set_val_s;
            end else if (cnt_q[r] != {CW{1'b0}}) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end else begin
                cnt_d[r] = {CW{1'b0}};
            end
            pending[r] = (cnt_q[r] != {CW{1'b0}});
        end
    end

    // Long-unit FSM next state
    always_comb begin
        state_d   = state_q;
        lcnt_d    = lcnt_q;
        long_rd_d = long_rd_q;
        case (state_q)
            IDLE: begin
                if (long_issue_s) begin
                    state_d   = BUSY;
                    lcnt_d    = CW'(LONG_LAT - 1);
                    long_rd_d = ID_rd;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (lcnt_q == CW'(1)) begin
                    state_d = DONE;
                end else begin
                    lcnt_d = lcnt_q - CW'(1);
                end
            end
            DONE: begin
                // DONE may accept the next long op so back-to-back ops lose no cycle
                if (long_issue_s) begin
                    state_d   = BUSY;
                    lcnt_d    = CW'(LONG_LAT - 1);
                    long_rd_d = ID_rd;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lcnt_q    <= {CW{1'b0}};
            long_rd_q <= 5'd0;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= {CW{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            lcnt_q    <= lcnt_d;
            long_rd_q <= long_rd_d;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign long_done = (state_q == DONE);
    assign long_rd   = long_rd_q;

endmodule
